// File: rtl/sync_fifo_pipe.sv
// Single-clock FIFO with inferred RAM storage, one- or two-stage registered read path,
// registered full/empty/threshold status, occupancy count, sticky error flags and flush.
module sync_fifo_pipe #(
  parameter int WIDTH      = 32,
  parameter int DEPTH      = 128,
  parameter int PIPE       = 1,
  parameter int AFULL_VAL  = 120,
  parameter int AEMPTY_VAL = 8,
  localparam int AW        = $clog2(DEPTH),
  localparam int CW        = AW + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             we,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  output logic [WIDTH-1:0] rdata,
  output logic             rvalid,
  output logic             full,
  output logic             empty,
  output logic             afull,
  output logic             aempty,
  output logic [CW-1:0]    wrcnt,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_VAL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_VAL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic [CW-1:0]    count_next;
  logic             wr_accept;
  logic             rd_accept;
  logic [WIDTH-1:0] q1;
  logic             v1;

  // Acceptance looks only at registered status, so a full FIFO never takes a write
  // even when a read drains it in the same cycle (and vice versa when empty).
  assign wr_accept = we && !full  && !flush;
  assign rd_accept = re && !empty && !flush;

  always_comb begin
    count_next = wrcnt;
    if (flush)
      count_next = '0;
    else if (wr_accept && !rd_accept)
      count_next = wrcnt + CW'(1);
    else if (rd_accept && !wr_accept)
      count_next = wrcnt - CW'(1);
  end

  always_ff @(posedge clock) begin
    if (wr_accept)
      mem[wptr] <= wdata;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wptr      <= '0;
      rptr      <= '0;
      wrcnt     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      afull     <= 1'b0;
      aempty    <= 1'b1;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (flush) begin
        wptr <= '0;
        rptr <= '0;
      end else begin
        if (wr_accept) wptr <= wptr + AW'(1);
        if (rd_accept) rptr <= rptr + AW'(1);
      end
      wrcnt     <= count_next;
      full      <= (count_next == DEPTH_C);
      empty     <= (count_next == '0);
      afull     <= (count_next >= AFULL_C);
      aempty    <= (count_next <= AEMPTY_C);
      overflow  <= !flush && (overflow  || (we && full));
      underflow <= !flush && (underflow || (re && empty));
    end
  end

  // First read stage: RAM output register, only loaded by accepted reads so it holds otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q1 <= '0;
      v1 <= 1'b0;
    end else begin
      v1 <= rd_accept;
      if (rd_accept)
        q1 <= mem[rptr];
    end
  end

  generate
    if (PIPE != 0) begin : g_pipe2
      logic [WIDTH-1:0] q2;
      logic             v2;

      // Flush cancels a word sitting in the first stage so it never surfaces.
      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          q2 <= '0;
          v2 <= 1'b0;
        end else begin
          v2 <= v1 && !flush;
          if (v1 && !flush)
            q2 <= q1;
        end
      end

      assign rdata  = q2;
      assign rvalid = v2;
    end else begin : g_pipe1
      assign rdata  = q1;
      assign rvalid = v1;
    end
  endgenerate

endmodule
